imm_inst_encoder: RTL and testbench
===================================

// Module: imm_inst_encoder
// PURPOSE
//  Inverse of the immediate generator: packs a 64-bit immediate plus register/funct3 fields
//  into a 32-bit RV64 instruction word, for I-ALU (0010011), load (0000011) and store (0100011).
//  Streams encoded words, each tagged with a byte address, to the instruction-memory loader
//  through a valid/ready handshake.
//  Checks that the immediate fits signed 12 bits; on a violation it halts in FAULT until cleared.
// PARAMETERS
//  ADDR_W     10  width of addr_o / address counter (bits)
//  BASE_ADDR  0   value addr_o takes after reset and after clear_i (multiple of 4)
// PORTS
//  clk_i        in   1       clock; all state on rising edge
//  rst_i        in   1       synchronous, active-high reset
//  in_valid_i   in   1       request valid
//  in_ready_o   out  1       request accepted when in_valid_i & in_ready_o
//  fmt_i        in   2       0=I, 1=L, 2=S, 3=reserved
//  rd_i         in   5       destination register (ignored for S)
//  rs1_i        in   5       base/source register 1
//  rs2_i        in   5       source register 2 (S only)
//  funct3_i     in   3       funct3 field, passed through unchanged
//  imm_i        in   64      sign-extended immediate
//  out_valid_o  out  1       inst_o/addr_o valid
//  out_ready_i  in   1       consumer takes word when out_valid_o & out_ready_i
//  inst_o       out  32      encoded instruction
//  addr_o       out  ADDR_W  byte address of inst_o
//  err_o        out  1       high while in FAULT
//  err_code_o   out  2       0=none, 1=imm out of range, 2=reserved fmt
//  clear_i      in   1       leave FAULT; reload address counter with BASE_ADDR
// BEHAVIOUR
//  Reset (sync, wins over every other input):
//   state=RUN, out_valid_o=0, inst_o=0, addr_o=BASE_ADDR, err_o=0, err_code_o=0.
//  Any output word pending at reset is discarded.
//  States: RUN, FAULT.
//  RUN:
//   in_ready_o = !out_valid_o | out_ready_i (single output register, full throughput).
//   Accept with a legal request -> on the next edge: inst_o = encoding, out_valid_o = 1.
//   Latency is 1 cycle.
//  Encoding:
//   I: {imm[11:0], rs1, funct3, rd, 7'b0010011}
//   L: {imm[11:0], rs1, funct3, rd, 7'b0000011}
//   S: {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011}
//  Range check: legal iff imm_i[63:11] is all 0s or all 1s.
//  Illegal request, or fmt_i=3, on accept:
//   - no word is produced
//   - state -> FAULT; err_o=1, err_code_o set (range error takes precedence over fmt)
//   - a word already in the output register still drains normally
//  Output hold: while out_valid_o & !out_ready_i, inst_o and addr_o stay stable.
//  Address: addr_o += 4 on each output handshake; wraps modulo 2^ADDR_W.
//  Simultaneous drain + accept: the new word is loaded, and addr_o advances by 4 exactly once.
//  FAULT:
//   - in_ready_o = 0
//   - clear_i -> RUN on the next edge: err_o=0, err_code_o=0, addr_o=BASE_ADDR
//   - a pending output word is kept on clear_i
//  clear_i in RUN: ignored.
// STRUCTURE
//  Package rv_enc_pkg:
//   - opcode localparams OP_IMM / OP_LOAD / OP_STORE
//   - fmt encoding
//   - err_code values
//  Sub-module rv_imm_pack: combinational field packer plus range check
//  (outputs inst[31:0], ok, code).
//  Top level holds the FSM, the output register and the address counter.
// TESTING
//  1. I, rd=5, rs1=6, f3=0, imm=-1 -> inst_o=0xFFF30293, addr_o=0, 1 cycle after accept.
//  2. L, rd=10, rs1=11, f3=3, imm=16 -> 0x0105B503.
//     S, rs1=2, rs2=7, f3=3, imm=8 -> 0x00713423 at addr 4.
//  3. imm=2048 -> no word, err_o=1, err_code_o=1, in_ready_o=0;
//     clear_i -> RUN, addr_o=BASE_ADDR.
//  4. out_ready_i low 3 cycles with a word pending -> inst_o/addr_o stable, in_ready_o=0;
//     back-to-back stream at ready=1 -> 1 word/cycle.
//  5. ADDR_W=4, 5 words -> addr_o 0,4,8,12,0.
//     rst_i with a word pending -> out_valid_o=0 next cycle.
//  6. Random legal requests -> the immediate generator applied to inst_o returns imm_i
//     (round-trip check).

Source files
------------

// File: rtl/rv_enc_pkg.sv
// rtl/rv_enc_pkg.sv - opcodes, format codes, error codes and FSM states for the encoder
package rv_enc_pkg;

    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        FMT_I   = 2'd0,
        FMT_L   = 2'd1,
        FMT_S   = 2'd2,
        FMT_RSV = 2'd3
    } fmt_e;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_RANGE = 2'd1,
        ERR_FMT   = 2'd2
    } err_code_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_e;

endpackage

// File: rtl/imm_inst_encoder_if.sv
// rtl/imm_inst_encoder_if.sv - request, output-stream and fault/clear signals of the encoder
interface imm_inst_encoder_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid_i;
    logic              in_ready_o;
    logic [1:0]        fmt_i;
    logic [4:0]        rd_i;
    logic [4:0]        rs1_i;
    logic [4:0]        rs2_i;
    logic [2:0]        funct3_i;
    logic [63:0]       imm_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [31:0]       inst_o;
    logic [ADDR_W-1:0] addr_o;
    logic              err_o;
    logic [1:0]        err_code_o;
    logic              clear_i;

    modport master (
        output in_valid_i, fmt_i, rd_i, rs1_i, rs2_i, funct3_i, imm_i, out_ready_i, clear_i,
        input  in_ready_o, out_valid_o, inst_o, addr_o, err_o, err_code_o
    );

    modport slave (
        input  in_valid_i, fmt_i, rd_i, rs1_i, rs2_i, funct3_i, imm_i, out_ready_i, clear_i,
        output in_ready_o, out_valid_o, inst_o, addr_o, err_o, err_code_o
    );
endinterface

// File: rtl/rv_imm_pack.sv
// rtl/rv_imm_pack.sv - combinational instruction field packer with signed-12-bit range check
module rv_imm_pack
    import rv_enc_pkg::*;
(
    input  logic [1:0]  fmt,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [63:0] imm,
    output logic [31:0] inst,
    output logic        ok,
    output logic [1:0]  code
);
    logic range_ok;

    // Fits in signed 12 bits when every bit from 11 upward equals the sign.
    assign range_ok = (&imm[63:11]) | ~(|imm[63:11]);

    always_comb begin
        inst = '0;
        code = ERR_NONE;
        case (fmt_e'(fmt))
            FMT_I:   inst = {imm[11:0], rs1, funct3, rd, OP_IMM};
            FMT_L:   inst = {imm[11:0], rs1, funct3, rd, OP_LOAD};
            FMT_S:   inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
            default: inst = '0;
        endcase
        if (!range_ok)
            code = ERR_RANGE;
        else if (fmt_e'(fmt) == FMT_RSV)
            code = ERR_FMT;
    end

    assign ok = (code == ERR_NONE);
endmodule

// File: rtl/imm_inst_encoder.sv
// rtl/imm_inst_encoder.sv - RUN/FAULT FSM, single output register and byte address counter
module imm_inst_encoder
    import rv_enc_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    imm_inst_encoder_if.slave bus
);
    state_e            state_q, state_d;
    logic [1:0]        err_code_q, err_code_d;
    logic              valid_q;
    logic [31:0]       inst_q;
    logic [ADDR_W-1:0] addr_q;

    logic [31:0] pack_inst;
    logic        pack_ok;
    logic [1:0]  pack_code;
    logic        accept;
    logic        drain;

    rv_imm_pack u_pack (
        .fmt    (bus.fmt_i),
        .rd     (bus.rd_i),
        .rs1    (bus.rs1_i),
        .rs2    (bus.rs2_i),
        .funct3 (bus.funct3_i),
        .imm    (bus.imm_i),
        .inst   (pack_inst),
        .ok     (pack_ok),
        .code   (pack_code)
    );

    assign bus.in_ready_o  = (state_q == ST_RUN) && (!valid_q || bus.out_ready_i);
    assign accept          = bus.in_valid_i && bus.in_ready_o;
    assign drain           = valid_q && bus.out_ready_i;
    assign bus.out_valid_o = valid_q;
    assign bus.inst_o      = inst_q;
    assign bus.addr_o      = addr_q;
    assign bus.err_o       = (state_q == ST_FAULT);
    assign bus.err_code_o  = err_code_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_RUN;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            err_code_q <= err_code_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        err_code_d = err_code_q;
        case (state_q)
            ST_RUN: begin
                if (accept && !pack_ok) begin
                    state_d    = ST_FAULT;
                    err_code_d = pack_code;
                end
            end
            ST_FAULT: begin
                if (bus.clear_i) begin
                    state_d    = ST_RUN;
                    err_code_d = ERR_NONE;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // A new word overwrites a draining one; the address still steps only once per handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            inst_q  <= '0;
            addr_q  <= ADDR_W'(BASE_ADDR);
        end else begin
            if (accept && pack_ok) begin
                valid_q <= 1'b1;
                inst_q  <= pack_inst;
            end else if (drain) begin
                valid_q <= 1'b0;
            end

            if (state_q == ST_FAULT && bus.clear_i)
                addr_q <= ADDR_W'(BASE_ADDR);
            else if (drain)
                addr_q <= addr_q + ADDR_W'(4);
        end
    end
endmodule

// File: tb/tb_imm_inst_encoder.sv
// tb/tb_imm_inst_encoder.sv - directed and round-trip checks of imm_inst_encoder
module tb_imm_inst_encoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst4 = 1'b1;
    int   n_vec = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    imm_inst_encoder_if #(.ADDR_W(10)) bus ();
    imm_inst_encoder_if #(.ADDR_W(4))  bus4 ();

    imm_inst_encoder #(.ADDR_W(10), .BASE_ADDR(0)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    imm_inst_encoder #(.ADDR_W(4), .BASE_ADDR(0)) dut4 (
        .clk_i (clk),
        .rst_i (rst4),
        .bus   (bus4)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid_i = 1'b0;
        bus.clear_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send(input logic [1:0] fmt, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [63:0] imm);
        bit done = 0;
        bus.fmt_i = fmt; bus.rd_i = rd; bus.rs1_i = rs1; bus.rs2_i = rs2;
        bus.funct3_i = f3; bus.imm_i = imm; bus.in_valid_i = 1'b1;
        #1;
        for (int c = 0; c < 20 && !done; c++) begin
            if (bus.in_ready_o) done = 1;
            tick();
        end
        bus.in_valid_i = 1'b0;
        if (!done) check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic clear_fault();
        bus.clear_i = 1'b1;
        tick();
        bus.clear_i = 1'b0;
    endtask

    initial begin
        logic [63:0] rimm;
        logic [63:0] dimm;
        logic [1:0]  rfmt;
        logic [31:0] w;
        longint      li;

        bus.in_valid_i = 0; bus.fmt_i = 0; bus.rd_i = 0; bus.rs1_i = 0; bus.rs2_i = 0;
        bus.funct3_i = 0; bus.imm_i = 0; bus.out_ready_i = 1; bus.clear_i = 0;
        bus4.in_valid_i = 0; bus4.fmt_i = 0; bus4.rd_i = 0; bus4.rs1_i = 0; bus4.rs2_i = 0;
        bus4.funct3_i = 0; bus4.imm_i = 0; bus4.out_ready_i = 1; bus4.clear_i = 0;

        do_reset();
        check("rst_valid", bus.out_valid_o, 0);
        check("rst_inst", bus.inst_o, 0);
        check("rst_addr", bus.addr_o, 0);
        check("rst_err", bus.err_o, 0);
        check("rst_code", bus.err_code_o, 0);
        check("rst_ready", bus.in_ready_o, 1);

        // I-format word held under backpressure
        bus.out_ready_i = 0;
        send(2'd0, 5'd5, 5'd6, 5'd0, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        check("t1_valid", bus.out_valid_o, 1);
        check("t1_inst", bus.inst_o, 32'hFFF30293);
        check("t1_addr", bus.addr_o, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_inst", bus.inst_o, 32'hFFF30293);
            check("hold_addr", bus.addr_o, 0);
            check("hold_ready", bus.in_ready_o, 0);
        end
        bus.out_ready_i = 1;
        tick();
        check("drain_valid", bus.out_valid_o, 0);
        check("drain_addr", bus.addr_o, 4);
        clear_fault();
        check("clr_run_addr", bus.addr_o, 4);
        check("clr_run_err", bus.err_o, 0);

        // L then S with simultaneous drain and accept
        do_reset();
        bus.out_ready_i = 0;
        send(2'd1, 5'd10, 5'd11, 5'd0, 3'd3, 64'd16);
        check("t2_l_inst", bus.inst_o, 32'h0105B503);
        check("t2_l_addr", bus.addr_o, 0);
        bus.out_ready_i = 1;
        send(2'd2, 5'd0, 5'd2, 5'd7, 3'd3, 64'd8);
        check("t2_s_valid", bus.out_valid_o, 1);
        check("t2_s_inst", bus.inst_o, 32'h00713423);
        check("t2_s_addr", bus.addr_o, 4);
        tick();
        check("t2_drain_addr", bus.addr_o, 8);
        send(2'd0, 5'd0, 5'd0, 5'd0, 3'd0, 64'd2047);
        check("max_imm_inst", bus.inst_o, 32'h7FF00013);
        check("max_imm_addr", bus.addr_o, 8);
        tick();
        send(2'd0, 5'd1, 5'd1, 5'd0, 3'd0, 64'hFFFF_FFFF_FFFF_F800);
        check("min_imm_inst", bus.inst_o, 32'h80008093);
        check("min_imm_err", bus.err_o, 0);
        tick();

        // Range fault while a pending word drains
        bus.out_ready_i = 0;
        send(2'd0, 5'd1, 5'd0, 5'd0, 3'd0, 64'd5);
        check("pend_addr", bus.addr_o, 16);
        bus.out_ready_i = 1;
        send(2'd0, 5'd1, 5'd0, 5'd0, 3'd0, 64'd2048);
        check("flt_valid", bus.out_valid_o, 0);
        check("flt_addr", bus.addr_o, 20);
        check("flt_err", bus.err_o, 1);
        check("flt_code", bus.err_code_o, 1);
        check("flt_ready", bus.in_ready_o, 0);
        clear_fault();
        check("clr_err", bus.err_o, 0);
        check("clr_code", bus.err_code_o, 0);
        check("clr_addr", bus.addr_o, 0);
        check("clr_ready", bus.in_ready_o, 1);
        send(2'd3, 5'd1, 5'd1, 5'd1, 3'd0, 64'd0);
        check("fmt_code", bus.err_code_o, 2);
        check("fmt_valid", bus.out_valid_o, 0);
        clear_fault();
        send(2'd3, 5'd1, 5'd1, 5'd1, 3'd0, 64'd2048);
        check("prec_code", bus.err_code_o, 1);
        clear_fault();

        // Back-to-back stream, one word per cycle
        do_reset();
        bus.out_ready_i = 1;
        bus.fmt_i = 2'd0; bus.rs1_i = 0; bus.rs2_i = 0; bus.funct3_i = 0;
        bus.in_valid_i = 1;
        for (int i = 0; i < 4; i++) begin
            bus.rd_i = 5'(i);
            bus.imm_i = 64'(i);
            tick();
            check("b2b_valid", bus.out_valid_o, 1);
            check("b2b_inst", bus.inst_o, (32'(i) << 20) | (32'(i) << 7) | 32'h13);
            check("b2b_addr", bus.addr_o, 64'(4 * i));
        end
        bus.in_valid_i = 0;
        tick();

        // Round trip through an immediate decoder
        for (int i = 0; i < 20; i++) begin
            li = longint'($urandom_range(0, 4095)) - 2048;
            rimm = li;
            rfmt = 2'($urandom_range(0, 2));
            send(rfmt, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), rimm);
            w = bus.inst_o;
            if (rfmt == 2'd2)
                dimm = {{52{w[31]}}, w[31:25], w[11:7]};
            else
                dimm = {{52{w[31]}}, w[31:20]};
            check("rt_imm", dimm, rimm);
            check("rt_op", w[6:0], rfmt == 2'd0 ? 7'b0010011 :
                                   rfmt == 2'd1 ? 7'b0000011 : 7'b0100011);
        end

        // Narrow address counter wraps
        repeat (2) tick();
        rst4 = 0;
        bus4.in_valid_i = 1;
        for (int i = 0; i < 5; i++) begin
            bus4.imm_i = 64'(i);
            tick();
            check("wrap_addr", bus4.addr_o, 64'((4 * i) % 16));
        end
        bus4.in_valid_i = 1;
        bus4.out_ready_i = 0;
        tick();
        bus4.in_valid_i = 0;
        check("pend4_valid", bus4.out_valid_o, 1);
        rst4 = 1;
        tick();
        check("rst_pend_valid", bus4.out_valid_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
